il_fill_responder_lv2: RTL and testbench

IL_FILL_RESPONDER_LV2 -- requirements
Module: il_fill_responder_lv2

---
 rtl/cache_pkg_lv2.sv | 18 +
 rtl/il_fill_timer.sv | 27 ++
 rtl/il_fill_responder_lv2.sv | 135 +++++++++++++
 tb/tb_il_fill_responder_lv2.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg_lv2.sv
// Shared types and default sizing for the L2 instruction-fill responder.
// Combinational definitions only; no latency or backpressure of its own.
package cache_pkg_lv2;

  localparam int ADDR_WID_DEF    = 32;
  localparam int DATA_WID_DEF    = 32;
  localparam int TIMEOUT_CYC_DEF = 255;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    CHECK,
    MEM_WAIT,
    RESP,
    DONE
  } il_fill_state_t;

endpackage

// File: rtl/il_fill_timer.sv
// MEM_WAIT cycle counter: clears on i_clr, counts on i_inc; value visible the cycle after.
// No backpressure; the owner decides when the count means expiry.
module il_fill_timer
  import cache_pkg_lv2::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/il_fill_responder_lv2.sv
// L2 fill responder for L1 IL: array lookup, memory fallback, one-cycle response strobe.
// Hit strobe 3 cycles after request; miss strobe 1 cycle after mem_rd_done; IL_FILL_TIMEOUT_EN bounds MEM_WAIT.
module il_fill_responder_lv2
  import cache_pkg_lv2::*;
#(
  parameter int ADDR_WID    = ADDR_WID_DEF,
  parameter int DATA_WID    = DATA_WID_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lv2_rd,
  input  logic [ADDR_WID-1:0] addr_bus_lv1_lv2,
  output logic [DATA_WID-1:0] data_bus_lv1_lv2,
  output logic                data_in_bus_lv1_lv2,
  output logic                arr_rd,
  output logic [ADDR_WID-1:0] arr_addr,
  input  logic                arr_hit,
  input  logic [DATA_WID-1:0] arr_data,
  output logic                mem_rd,
  output logic [ADDR_WID-1:0] mem_addr,
  input  logic                mem_rd_done,
  input  logic [DATA_WID-1:0] mem_data,
  output logic                fill_err
);

  if (TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("il_fill_responder_lv2: TIMEOUT_CYC must be at least 1");
  end

  il_fill_state_t      r_state;
  logic [ADDR_WID-1:0] r_addr;
  logic [DATA_WID-1:0] r_data;
  logic                r_arr_rd;
  logic                r_mem_rd;
  logic                r_resp;
  logic                w_expired;

`ifdef IL_FILL_TIMEOUT_EN
  localparam int                LP_CW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [LP_CW-1:0] LP_LAST = LP_CW'(TIMEOUT_CYC - 1);

  logic [LP_CW-1:0] w_cnt;
  logic             r_err;

  il_fill_timer #(
    .CNT_W (LP_CW)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .i_clr (r_state == CHECK && !arr_hit),
    .i_inc (r_state == MEM_WAIT),
    .o_cnt (w_cnt)
  );

  // Count reaches TIMEOUT_CYC on the edge closing the last allowed wait cycle.
  assign w_expired = (r_state == MEM_WAIT) && (w_cnt == LP_LAST);
  assign fill_err  = r_err;
`else
  assign w_expired = 1'b0;
  assign fill_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_data   <= '0;
      r_arr_rd <= 1'b0;
      r_mem_rd <= 1'b0;
      r_resp   <= 1'b0;
`ifdef IL_FILL_TIMEOUT_EN
      r_err    <= 1'b0;
`endif
    end else begin
      r_arr_rd <= 1'b0;
      r_resp   <= 1'b0;
`ifdef IL_FILL_TIMEOUT_EN
      r_err    <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (lv2_rd) begin
            r_addr   <= addr_bus_lv1_lv2;
            r_arr_rd <= 1'b1;
            r_state  <= LOOKUP;
          end
        end
        LOOKUP: r_state <= CHECK;
        CHECK: begin
          if (arr_hit) begin
            r_data  <= arr_data;
            r_resp  <= 1'b1;
            r_state <= RESP;
          end else begin
            r_mem_rd <= 1'b1;
            r_state  <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          // A completion in the final allowed cycle wins over the timeout.
          if (mem_rd_done) begin
            r_data   <= mem_data;
            r_mem_rd <= 1'b0;
            r_resp   <= 1'b1;
            r_state  <= RESP;
          end else if (w_expired) begin
            r_data   <= '0;
            r_mem_rd <= 1'b0;
            r_resp   <= 1'b1;
            r_state  <= RESP;
`ifdef IL_FILL_TIMEOUT_EN
            r_err    <= 1'b1;
`endif
          end
        end
        RESP: r_state <= DONE;
        DONE: begin
          if (!lv2_rd) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign arr_rd              = r_arr_rd;
  assign arr_addr            = r_addr;
  assign mem_rd              = r_mem_rd;
  assign mem_addr            = r_addr;
  assign data_in_bus_lv1_lv2 = r_resp;
  assign data_bus_lv1_lv2    = r_resp ? r_data : '0;

endmodule

// File: tb/tb_il_fill_responder_lv2.sv
// Transaction-timeline bench for il_fill_responder_lv2: expected outputs per cycle offset.
// Honours IL_FILL_TIMEOUT_EN with TIMEOUT_CYC fixed at 8.
module tb_il_fill_responder_lv2;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;
`ifdef IL_FILL_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          lv2_rd;
  logic [AW-1:0] addr_bus_lv1_lv2;
  logic [DW-1:0] data_bus_lv1_lv2;
  logic          data_in_bus_lv1_lv2;
  logic          arr_rd;
  logic [AW-1:0] arr_addr;
  logic          arr_hit;
  logic [DW-1:0] arr_data;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_done;
  logic [DW-1:0] mem_data;
  logic          fill_err;

  int n_vec = 0;
  int n_bad = 0;

  il_fill_responder_lv2 #(
    .ADDR_WID    (AW),
    .DATA_WID    (DW),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .lv2_rd              (lv2_rd),
    .addr_bus_lv1_lv2    (addr_bus_lv1_lv2),
    .data_bus_lv1_lv2    (data_bus_lv1_lv2),
    .data_in_bus_lv1_lv2 (data_in_bus_lv1_lv2),
    .arr_rd              (arr_rd),
    .arr_addr            (arr_addr),
    .arr_hit             (arr_hit),
    .arr_data            (arr_data),
    .mem_rd              (mem_rd),
    .mem_addr            (mem_addr),
    .mem_rd_done         (mem_rd_done),
    .mem_data            (mem_data),
    .fill_err            (fill_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Check this cycle's outputs at the falling edge, then move to just after the next rising edge.
  task automatic tick(input string ph, input bit e_arr, input bit e_mem, input bit e_stb,
                      input logic [31:0] e_dat, input bit e_err, input logic [31:0] e_addr);
    @(negedge clk);
    chk({ph, ".arr_rd"}, 32'(arr_rd), 32'(e_arr));
    if (e_arr) chk({ph, ".arr_addr"}, arr_addr, e_addr);
    chk({ph, ".mem_rd"}, 32'(mem_rd), 32'(e_mem));
    if (e_mem) chk({ph, ".mem_addr"}, mem_addr, e_addr);
    chk({ph, ".strobe"}, 32'(data_in_bus_lv1_lv2), 32'(e_stb));
    chk({ph, ".data"}, data_bus_lv1_lv2, e_dat);
    chk({ph, ".fill_err"}, 32'(fill_err), 32'(e_err));
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    arr_hit          = 1'($urandom);
    arr_data         = $urandom;
    mem_rd_done      = 1'($urandom);
    mem_data         = $urandom;
  endtask

  // One fill: d = memory cycles to completion, early = drop lv2_rd after capture,
  // hold = extra DONE cycles with lv2_rd still high.
  task automatic txn(input logic [31:0] a, input bit hit, input logic [31:0] ad, input int d,
                     input logic [31:0] md, input bit early, input int hold);
    int s;
    bit to;
    logic [31:0] exp_d;
    to    = !hit && TMO_EN && (d > TMO);
    s     = hit ? 3 : 3 + (to ? TMO : d);
    exp_d = hit ? ad : (to ? 32'h0 : md);
    noise();
    lv2_rd = 1'b1;
    addr_bus_lv1_lv2 = a;
    tick("idle", 0, 0, 0, 0, 0, a);
    for (int k = 1; k <= s; k++) begin
      noise();
      addr_bus_lv1_lv2 = $urandom;
      lv2_rd = !early;
      if (k == 2) begin
        arr_hit  = hit;
        arr_data = ad;
      end
      if (!hit && k >= 3 && k < s) begin
        mem_rd_done = !to && (k == s - 1);
        mem_data    = mem_rd_done ? md : $urandom;
      end
      tick((k == s) ? "resp" : "busy", k == 1, !hit && k >= 3 && k < s, k == s,
           (k == s) ? exp_d : 32'h0, (k == s) && to, a);
    end
    for (int h = 0; h < (early ? 0 : hold); h++) begin
      noise();
      lv2_rd = 1'b1;
      tick("done_hold", 0, 0, 0, 0, 0, a);
    end
    noise();
    lv2_rd = 1'b0;
    tick("done", 0, 0, 0, 0, 0, a);
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      noise();
      lv2_rd = 1'b0;
      tick("gap", 0, 0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    lv2_rd = 1'b0;
    addr_bus_lv1_lv2 = '0;
    arr_hit = 1'b0;
    arr_data = '0;
    mem_rd_done = 1'b0;
    mem_data = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    tick("reset", 0, 0, 0, 0, 0, 0);
    chk("reset.addr", mem_addr, 32'h0);
    rst = 1'b0;
    idle_gap(2);

    txn(32'h0000_1040, 1, 32'hDEAD_BEEF, 0, 32'h0, 0, 0);
    txn(32'h0000_1040, 0, 32'h0, 5, 32'h1234_5678, 0, 0);
    txn(32'h0000_1040, 0, 32'h0, 3, 32'hCAFE_0001, 1, 0);
    txn(32'h0000_1040, 1, 32'h5555_AAAA, 0, 32'h0, 1, 0);
    txn(32'h0000_2000, 1, 32'h0BAD_F00D, 0, 32'h0, 0, 3);
    txn(32'h0000_2004, 0, 32'h0, 1, 32'h7777_0001, 0, 0);
    txn(32'h0000_2008, 0, 32'h0, TMO, 32'h8888_0002, 0, 0);
    txn(32'h0000_200C, 0, 32'h0, 20, 32'h9999_0003, 0, 1);

    // Reset while waiting on memory.
    noise();
    lv2_rd = 1'b1;
    addr_bus_lv1_lv2 = 32'h0000_3000;
    tick("r_idle", 0, 0, 0, 0, 0, 32'h0000_3000);
    for (int k = 1; k <= 4; k++) begin
      noise();
      if (k >= 2) arr_hit = 1'b0;
      if (k >= 3) mem_rd_done = 1'b0;
      rst = (k == 4);
      lv2_rd = (k < 4);
      tick("r_busy", k == 1, k >= 3, 0, 0, 0, 32'h0000_3000);
    end
    for (int k = 0; k < 3; k++) begin
      noise();
      rst = (k == 0);
      lv2_rd = 1'b0;
      tick("r_after", 0, 0, 0, 0, 0, 0);
      chk("r_after.addr", mem_addr, 32'h0);
    end
    txn(32'h0000_3004, 0, 32'h0, 2, 32'h4242_4242, 0, 0);

    for (int t = 0; t < 30; t++) begin
      txn($urandom, 1'($urandom), $urandom, $urandom_range(1, 12), $urandom,
          ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
      idle_gap($urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
